// File: rtl/formula_sweep_ctrl.sv
// formula_sweep_ctrl
//   Sweeps an assignment range through one combinational formula evaluator,
//   one vector per cycle. It tracks each issued vector through the
//   evaluator latency, counts satisfying and total results, and captures the
//   first falsifying assignment as a counterexample.
//
// State table
//   S_IDLE  | after reset, waiting for start
//   S_RUN   | issuing one vector per cycle
//   S_DRAIN | issuing stopped, waiting for in-flight results
//   S_DONE  | results stable, waiting for the next start
//
// Ports
//   clk, rst                  clock, async active-high reset
//   start, abort              sweep control (start honoured in IDLE/DONE only)
//   stop_on_fail              halt issuing at the first falsifying result
//   first_vec, last_vec       inclusive sweep range, latched at start
//   vec, vec_valid            request to the evaluator
//   eval_o                    evaluator result, EVAL_LAT cycles after vec
//   busy, done                RUN/DRAIN, and DONE level
//   fail_found, aborted       sweep status flags
//   cex_vec                   first falsifying assignment
//   sat_cnt, eval_cnt         satisfying / total accepted results
module formula_sweep_ctrl #(
  parameter int N_IN     = 31,
  parameter int EVAL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            stop_on_fail,
  input  logic [N_IN-1:0] first_vec,
  input  logic [N_IN-1:0] last_vec,
  output logic [N_IN-1:0] vec,
  output logic            vec_valid,
  input  logic            eval_o,
  output logic            busy,
  output logic            done,
  output logic            fail_found,
  output logic            aborted,
  output logic [N_IN-1:0] cex_vec,
  output logic [N_IN:0]   sat_cnt,
  output logic [N_IN:0]   eval_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};

  state_t          state_q, state_d;
  logic [N_IN-1:0] next_q, next_d;
  logic [N_IN-1:0] last_q, last_d;
  logic            sof_q, sof_d;
  logic            fail_q, fail_d;
  logic            abort_q, abort_d;
  logic [N_IN-1:0] cex_q, cex_d;
  logic [N_IN:0]   sat_q, sat_d;
  logic [N_IN:0]   evc_q, evc_d;

  // Tag pipeline; stage 0 holds the newest issue, stage EVAL_LAT-1 the head.
  logic [EVAL_LAT-1:0]           pv_q, pv_d;
  logic [EVAL_LAT-1:0]           pdis_q, pdis_d;
  logic [EVAL_LAT-1:0][N_IN-1:0] pvec_q, pvec_d;

  logic accept;
  logic new_fail;
  logic kill;
  logic issue;

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    last_d  = last_q;
    sof_d   = sof_q;
    fail_d  = fail_q;
    abort_d = abort_q;
    cex_d   = cex_q;
    sat_d   = sat_q;
    evc_d   = evc_q;

    issue    = (state_q == S_RUN);
    accept   = pv_q[EVAL_LAT-1] & ~pdis_q[EVAL_LAT-1];
    new_fail = accept & ~eval_o & ~fail_q;
    // First failure under stop_on_fail voids everything issued after it,
    // including the vector being pushed this very cycle.
    kill     = new_fail & sof_q;

    pv_d[0]   = issue;
    pvec_d[0] = next_q;
    pdis_d[0] = kill;
    for (int i = 1; i < EVAL_LAT; i++) begin
      pv_d[i]   = pv_q[i-1];
      pvec_d[i] = pvec_q[i-1];
      pdis_d[i] = pdis_q[i-1] | kill;
    end

    if (accept) begin
      if (evc_q != CNT_MAX) evc_d = evc_q + 1'b1;
      if (eval_o && (sat_q != CNT_MAX)) sat_d = sat_q + 1'b1;
      if (new_fail) begin
        fail_d = 1'b1;
        cex_d  = pvec_q[EVAL_LAT-1];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          next_d  = first_vec;
          last_d  = last_vec;
          sof_d   = stop_on_fail;
          fail_d  = 1'b0;
          abort_d = 1'b0;
          cex_d   = '0;
          sat_d   = '0;
          evc_d   = '0;
          state_d = (first_vec > last_vec) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) abort_d = 1'b1;
        // Compare before incrementing so an all-ones last_vec never wraps.
        if (kill || abort || (next_q == last_q)) state_d = S_DRAIN;
        else next_d = next_q + 1'b1;
      end
      S_DRAIN: begin
        if (abort) abort_d = 1'b1;
        // Leave as the head retires so done lands one cycle after the last result.
        if (pv_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      next_q  <= '0;
      last_q  <= '0;
      sof_q   <= 1'b0;
      fail_q  <= 1'b0;
      abort_q <= 1'b0;
      cex_q   <= '0;
      sat_q   <= '0;
      evc_q   <= '0;
      pv_q    <= '0;
      pdis_q  <= '0;
      pvec_q  <= '0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      last_q  <= last_d;
      sof_q   <= sof_d;
      fail_q  <= fail_d;
      abort_q <= abort_d;
      cex_q   <= cex_d;
      sat_q   <= sat_d;
      evc_q   <= evc_d;
      pv_q    <= pv_d;
      pdis_q  <= pdis_d;
      pvec_q  <= pvec_d;
    end
  end

  assign vec        = next_q;
  assign vec_valid  = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign fail_found = fail_q;
  assign aborted    = abort_q;
  assign cex_vec    = cex_q;
  assign sat_cnt    = sat_q;
  assign eval_cnt   = evc_q;

endmodule

// File: tb/tb_formula_sweep_ctrl.sv
// Bench for formula_sweep_ctrl: two N_IN=4 instances (EVAL_LAT 1 and 2),
// each driving a truth-table evaluator stub with matching latency.
module tb_formula_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s, start_s, abort_s, sof_s;
  logic [3:0] first_s [2];
  logic [3:0] last_s  [2];
  logic [3:0] vec_s   [2];
  logic [3:0] cex_s   [2];
  logic [4:0] sat_s   [2];
  logic [4:0] evc_s   [2];
  logic [1:0] vv_s, eval_s, busy_s, done_s, ff_s, ab_s;

  logic [15:0] tt  [2];
  logic [3:0]  dl0 [2];
  logic [3:0]  dl1 [2];

  int checks = 0;
  int passes = 0;

  formula_sweep_ctrl #(.N_IN(4), .EVAL_LAT(1)) dut0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
    .stop_on_fail(sof_s[0]), .first_vec(first_s[0]), .last_vec(last_s[0]),
    .vec(vec_s[0]), .vec_valid(vv_s[0]), .eval_o(eval_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .fail_found(ff_s[0]), .aborted(ab_s[0]),
    .cex_vec(cex_s[0]), .sat_cnt(sat_s[0]), .eval_cnt(evc_s[0]));

  formula_sweep_ctrl #(.N_IN(4), .EVAL_LAT(2)) dut1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
    .stop_on_fail(sof_s[1]), .first_vec(first_s[1]), .last_vec(last_s[1]),
    .vec(vec_s[1]), .vec_valid(vv_s[1]), .eval_o(eval_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .fail_found(ff_s[1]), .aborted(ab_s[1]),
    .cex_vec(cex_s[1]), .sat_cnt(sat_s[1]), .eval_cnt(evc_s[1]));

  // Evaluator stubs: truth table lookup of the vector issued EVAL_LAT cycles ago.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      dl0[d] <= vec_s[d];
      dl1[d] <= dl0[d];
    end
  end
  assign eval_s[0] = tt[0][dl0[0]];
  assign eval_s[1] = tt[1][dl1[1]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: what a sweep should do, worked out from the range, the truth
  // table, the latency and the abort cycle (a = cycles after start, 0 = none).
  function automatic void model(input int f, input int l, input bit sof,
                                input logic [15:0] t, input int lat, input int a,
                                output int k, output int evc, output int sat,
                                output bit ff, output int cex, output bit ab);
    int j, acc;
    k = 0; evc = 0; sat = 0; ff = 0; cex = 0; ab = 0;
    if (f > l) return;
    k = l - f + 1;
    if (a > 0 && a < k) k = a;
    j = -1;
    for (int i = 0; i < k; i++)
      if (!t[f+i]) begin j = i; break; end
    if (j >= 0) begin
      ff  = 1;
      cex = f + j;
      if (sof && (j + lat + 1 < k)) k = j + lat + 1;
    end
    acc = (j >= 0 && sof) ? j + 1 : k;
    evc = acc;
    for (int i = 0; i < acc; i++) if (t[f+i]) sat++;
    ab = (a > 0 && a <= k + lat);
  endfunction

  task automatic sweep(input int d, input int f, input int l, input bit sof,
                       input int a, input string tag);
    int lat, k, e_evc, e_sat, e_cex, done_n, iss_n;
    bit e_ff, e_ab, busy_ok, seq_ok;
    logic [63:0] snap;
    lat = d + 1;
    model(f, l, sof, tt[d], lat, a, k, e_evc, e_sat, e_ff, e_cex, e_ab);
    busy_ok = 1; seq_ok = 1; iss_n = 0; done_n = -1;

    @(negedge clk);
    first_s[d] = 4'(f); last_s[d] = 4'(l); sof_s[d] = sof; start_s[d] = 1'b1;
    @(posedge clk);
    #1 start_s[d] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done_s[d]) begin done_n = n; break; end
      if (!busy_s[d]) busy_ok = 0;
      if (vv_s[d]) begin
        if (int'(vec_s[d]) != f + iss_n) seq_ok = 0;
        iss_n++;
      end
      abort_s[d] = (n == a - 1);
    end
    abort_s[d] = 1'b0;

    check({tag, "_done_cycle"}, 64'(done_n), (f > l) ? 64'd0 : 64'(k + lat));
    check({tag, "_issued"}, 64'(iss_n), 64'(k));
    check({tag, "_vec_order"}, 64'(seq_ok), 64'd1);
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_eval_cnt"}, 64'(evc_s[d]), 64'(e_evc));
    check({tag, "_sat_cnt"}, 64'(sat_s[d]), 64'(e_sat));
    check({tag, "_fail_found"}, 64'(ff_s[d]), 64'(e_ff));
    check({tag, "_cex_vec"}, 64'(cex_s[d]), 64'(e_cex));
    check({tag, "_aborted"}, 64'(ab_s[d]), 64'(e_ab));
    check({tag, "_idle_at_done"}, {62'd0, vv_s[d], busy_s[d]}, 64'd0);
    snap = {40'd0, evc_s[d], sat_s[d], ff_s[d], ab_s[d], cex_s[d], 8'd0};
    repeat (3) @(negedge clk);
    check({tag, "_stable"},
          {40'd0, evc_s[d], sat_s[d], ff_s[d], ab_s[d], cex_s[d], done_s[d], 7'd0},
          snap | 64'h80);
  endtask

  function automatic logic [63:0] all_out(input int d);
    return {40'd0, vec_s[d], vv_s[d], busy_s[d], done_s[d], ff_s[d], ab_s[d],
            cex_s[d], sat_s[d], evc_s[d]};
  endfunction

  initial begin
    int d, f, l, a;
    bit sof;
    rst_s = 2'b11; start_s = '0; abort_s = '0; sof_s = '0;
    for (int i = 0; i < 2; i++) begin
      first_s[i] = '0; last_s[i] = '0; tt[i] = 16'hFFFF;
    end
    #22;
    check("reset_dut0", all_out(0), 64'd0);
    check("reset_dut1", all_out(1), 64'd0);
    @(negedge clk);
    rst_s = 2'b00;

    tt[0] = 16'hFFFF;
    sweep(0, 0, 15, 0, 0, "all_sat");
    tt[1] = 16'hFFDF;
    sweep(1, 0, 15, 1, 0, "stop_fail");
    sweep(1, 0, 15, 0, 0, "no_stop");
    sweep(0, 9, 3, 0, 0, "empty");
    sweep(0, 14, 15, 0, 0, "top_range");
    sweep(0, 0, 15, 0, 4, "abort");
    sweep(1, 0, 15, 1, 3, "abort_and_stop");

    // Reset in the middle of a sweep, then a clean sweep to show no stale tags.
    @(negedge clk);
    first_s[1] = 4'd0; last_s[1] = 4'd15; sof_s[1] = 1'b0; start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst_s[1] = 1'b1;
    #1 check("mid_reset_outputs", all_out(1), 64'd0);
    @(negedge clk);
    rst_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_reset_stays_idle", all_out(1), 64'd0);
    tt[1] = 16'hF7FF;
    sweep(1, 2, 13, 0, 0, "after_reset");

    for (int it = 0; it < 40; it++) begin
      d   = int'($urandom_range(0, 1));
      tt[d] = 16'($urandom) | 16'($urandom);
      f   = int'($urandom_range(0, 15));
      l   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(f, 15));
      sof = 1'($urandom);
      a   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
      sweep(d, f, l, sof, a, $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
